// File: rtl/riscv_pkg.sv
// Types and constants shared across the riscv32i pipeline stages.
// The IF/ID register layout lives here so the fetch and decode stages agree on it.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush drops the entry and plants a NOP; kill only drops it.
// Flush beats kill, and kill beats load.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   kill,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.valid    <= 1'b0;
      q.pc       <= RESET_PC;
      q.pc_plus4 <= RESET_PC + 32'd4;
      q.instr    <= NOP_INSTR;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (kill) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, feeds instr_mem, and fills the IF/ID register for decode.
// Redirects flush the register; a misaligned target parks the stage in FAULT until an aligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr,
  output logic            misalign_exc,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     fetch_count
);

  import riscv_pkg::*;

  // Handshake: a transfer to decode happens on an edge where id_valid && id_ready.
  // The IF/ID register may take a new instruction whenever it is empty or being drained.
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            exc_q, exc_d;
  logic [31:0]     count_q;
  logic            load, flush, kill;
  logic            advance, aligned, transfer;
  if_id_t          id_d, id_q;

  assign advance  = !id_q.valid || id_ready;
  assign aligned  = (redirect_pc[1:0] == 2'b00);
  assign transfer = id_q.valid && id_ready;

  always_comb begin
    id_d.valid    = 1'b1;
    id_d.pc       = pc_q;
    id_d.pc_plus4 = pc_q + 32'd4;
    id_d.instr    = imem_instr;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    exc_d      = exc_q;
    load       = 1'b0;
    flush      = 1'b0;
    kill       = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid && aligned) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (redirect_valid) begin
          state_d    = FAULT;
          fault_pc_d = redirect_pc;
          exc_d      = 1'b1;
          kill       = 1'b1;
        end else if (advance) begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      FAULT: begin
        if (redirect_valid && aligned) begin
          state_d = RUN;
          pc_d    = redirect_pc;
          exc_d   = 1'b0;
        end else if (redirect_valid) begin
          fault_pc_d = redirect_pc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      exc_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      exc_q      <= exc_d;
      // Counted in both states so a transfer on the same edge as a redirect is not lost.
      if (transfer) count_q <= count_q + 32'd1;
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (flush),
    .kill  (kill),
    .d     (id_d),
    .q     (id_q)
  );

  assign imem_addr    = pc_q;
  assign id_valid     = id_q.valid;
  assign id_pc        = id_q.pc;
  assign id_pc_plus4  = id_q.pc_plus4;
  assign id_instr     = id_q.instr;
  assign misalign_exc = exc_q;
  assign fault_pc     = fault_pc_q;
  assign fetch_count  = count_q;

endmodule
